fetch_queue: RTL and testbench

Parametrised instruction-fetch queue between the ibus and decode. Owns the fetch PC, keeps at most one ibus request in flight, buffers up to DEPTH returned instructions with their PCs, and presents them in order to decode through a valid/ready handshake. A redirect (branch, jump or flush) empties the queue and restarts fetch at a new PC. A response still in flight at redirect time is drained and discarded, because the bus request cannot be withdrawn.

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 150 +++++++++++++++
 tb/tb_fetch_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: ibus request/response, redirect, and decode handshake.
//   master : fetch_queue side (drives ireq_*, out_*, count)
//   slave  : environment side (drives iresp_*, redirect_*, out_ready)
interface fetch_queue_if #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned CNT_W   = 3
);
   logic               ireq_valid;
   logic [ADDR_W-1:0]  ireq_addr;
   logic               iresp_data_ok;
   logic [INSTR_W-1:0] iresp_data;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               out_valid;
   logic [ADDR_W-1:0]  out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic               out_ready;
   logic [CNT_W-1:0]   count;

   modport master (
      output ireq_valid, ireq_addr, out_valid, out_pc, out_instr, count,
      input  iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
   );

   modport slave (
      input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr, count,
      output iresp_data_ok, iresp_data, redirect_valid, redirect_pc, out_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: owns the fetch PC, keeps one ibus request in flight,
// buffers up to DEPTH {pc, instr} entries and hands them to decode in order.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fetch_queue_if.master (ibus request/response, redirect, decode handshake, count)
module fetch_queue #(
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       ADDR_W   = 64,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
   input logic           clk,
   input logic           reset,
   fetch_queue_if.master bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic [ADDR_W-1:0]   r_drain_addr;
   logic [ADDR_W-1:0]   w_drain_addr_nxt;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [ADDR_W-1:0]   r_pc_mem    [DEPTH];
   logic [INSTR_W-1:0]  r_instr_mem [DEPTH];

   logic                w_out_valid;
   logic                w_pop;
   logic                w_wr_en;
   logic                w_clear;
   logic [CNT_W-1:0]    w_cnt_after_pop;
   logic [CNT_W-1:0]    w_cnt_after_wr;

   // Redirect hides the head so a pop can never coincide with a flush
   assign w_out_valid     = (r_count != '0) & ~bus.redirect_valid;
   assign w_pop           = w_out_valid & bus.out_ready;
   // pop implies count != 0, so neither expression can wrap
   assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
   assign w_cnt_after_wr  = w_cnt_after_pop + CNT_W'(1);

   // Next-state, PC and queue-control decode
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_drain_addr_nxt = r_drain_addr;
      w_wr_en          = 1'b0;
      w_clear          = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.redirect_valid) begin
               w_clear     = 1'b1;
               w_pc_nxt    = bus.redirect_pc;
               w_state_nxt = ST_REQ;
            end else if (w_cnt_after_pop < FULL) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus.redirect_valid && bus.iresp_data_ok) begin
               w_clear     = 1'b1;
               w_pc_nxt    = bus.redirect_pc;
               w_state_nxt = ST_REQ;
            end else if (bus.redirect_valid) begin
               // Bus cannot withdraw the request: remember it and drain
               w_clear          = 1'b1;
               w_pc_nxt         = bus.redirect_pc;
               w_drain_addr_nxt = r_pc;
               w_state_nxt      = ST_DRAIN;
            end else if (bus.iresp_data_ok) begin
               w_wr_en     = 1'b1;
               w_pc_nxt    = r_pc + ADDR_W'(4);
               w_state_nxt = (w_cnt_after_wr < FULL) ? ST_REQ : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (bus.redirect_valid) begin
               w_clear     = 1'b1;
               w_pc_nxt    = bus.redirect_pc;
               w_state_nxt = bus.iresp_data_ok ? ST_REQ : ST_DRAIN;
            end else if (bus.iresp_data_ok) begin
               w_state_nxt = ST_REQ;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, fetch PC and drain address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_drain_addr <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_drain_addr <= w_drain_addr_nxt;
      end
   end

   // Pointers and occupancy; write and pop together leave count unchanged
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_wr_en ? w_cnt_after_wr : w_cnt_after_pop;
      end
   end

   // Entry storage; no reset needed, validity is tracked by count
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_pc_mem[r_wr_ptr]    <= r_pc;
         r_instr_mem[r_wr_ptr] <= bus.iresp_data;
      end
   end

   assign bus.ireq_valid = (r_state != ST_IDLE);
   assign bus.ireq_addr  = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_pc     = r_pc_mem[r_rd_ptr];
   assign bus.out_instr  = r_instr_mem[r_rd_ptr];
   assign bus.count      = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all checked
// against a transaction-level model (entry queue + in-flight request record).
module tb_fetch_queue;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam logic [63:0] RST_PC  = 64'h8000_0000;

   logic clk;
   logic reset;

   fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

   fetch_queue #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        q[$];
   logic [63:0] m_pc;
   logic [63:0] m_addr;
   bit          m_out;
   bit          m_drop;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc   = RST_PC;
      m_addr = '0;
      m_out  = 0;
      m_drop = 0;
   endtask

   // One clock: drive at negedge, compare before the posedge, then advance the model
   task automatic cycle(input bit rd, input logic [63:0] rpc, input bit dok_req,
                        input bit rdy, input bit rnd);
      bit          dok;
      bit          exp_ov;
      logic [31:0] data;
      @(negedge clk);
      dok  = dok_req && m_out;
      data = rnd ? 32'($urandom) : m_addr[31:0];
      bus.redirect_valid = rd;
      bus.redirect_pc    = rpc;
      bus.iresp_data_ok  = dok;
      bus.iresp_data     = data;
      bus.out_ready      = rdy;
      #1;
      exp_ov = (q.size() != 0) && !rd;
      check("ireq_valid", 64'(bus.ireq_valid), 64'(m_out));
      if (m_out) check("ireq_addr", bus.ireq_addr, m_addr);
      check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
      if (exp_ov) begin
         check("out_pc", bus.out_pc, q[0].pc);
         check("out_instr", 64'(bus.out_instr), 64'(q[0].instr));
      end
      check("count", 64'(bus.count), 64'(q.size()));
      // Effects of the coming edge
      if (exp_ov && rdy) void'(q.pop_front());
      if (rd) begin
         q.delete();
         m_pc = rpc;
         if (!m_out || dok) begin
            m_out  = 1;
            m_addr = rpc;
            m_drop = 0;
         end else begin
            m_drop = 1;
         end
      end else if (m_out && dok) begin
         if (m_drop) begin
            m_drop = 0;
            m_addr = m_pc;
         end else begin
            q.push_back('{pc: m_addr, instr: data});
            m_pc = m_addr + 64'd4;
            if (q.size() < DEPTH) m_addr = m_pc;
            else m_out = 0;
         end
      end else if (!m_out) begin
         if (q.size() < DEPTH) begin
            m_out  = 1;
            m_addr = m_pc;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.iresp_data_ok  = 1'b0;
      bus.out_ready      = 1'b0;
      #1;
      check("rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_count", 64'(bus.count), 64'd0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      reset              = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.iresp_data_ok  = 1'b0;
      bus.iresp_data     = '0;
      bus.out_ready      = 1'b0;
      model_reset();

      // Streaming: data_ok on every request, decode always ready
      do_reset();
      for (int i = 0; i < 12; i++) cycle(0, '0, 1, 1, 0);
      check("stream_count_max1", 64'(bus.count <= 1), 64'd1);

      // Fill with decode stalled, then one pop restarts fetch at 8000_0010
      do_reset();
      for (int i = 0; i < 7; i++) cycle(0, '0, 1, 0, 0);
      check("full_count", 64'(bus.count), 64'd4);
      check("full_idle", 64'(bus.ireq_valid), 64'd0);
      cycle(0, '0, 0, 1, 0);
      cycle(0, '0, 0, 0, 0);
      check("refill_addr", bus.ireq_addr, 64'h8000_0010);

      // Redirect while the request to 8000_0008 is waiting
      do_reset();
      cycle(0, '0, 0, 1, 0);
      cycle(0, '0, 1, 1, 0);
      cycle(0, '0, 1, 1, 0);
      cycle(1, 64'h8000_0100, 0, 1, 0);
      cycle(0, '0, 0, 1, 0);
      check("drain_addr", bus.ireq_addr, 64'h8000_0008);
      cycle(0, '0, 0, 1, 0);
      cycle(0, '0, 1, 1, 0);
      cycle(0, '0, 0, 1, 0);
      check("post_drain_addr", bus.ireq_addr, 64'h8000_0100);
      check("post_drain_count", 64'(bus.count), 64'd0);

      // Redirect and data_ok together with two entries queued
      do_reset();
      cycle(0, '0, 0, 0, 0);
      cycle(0, '0, 1, 0, 0);
      cycle(0, '0, 1, 0, 0);
      cycle(1, 64'h8000_0300, 1, 1, 0);
      cycle(0, '0, 0, 0, 0);
      check("rd_dok_addr", bus.ireq_addr, 64'h8000_0300);

      // Full queue, pop and redirect in the same cycle
      do_reset();
      for (int i = 0; i < 7; i++) cycle(0, '0, 1, 0, 0);
      cycle(1, 64'h8000_0200, 0, 1, 0);
      cycle(0, '0, 0, 0, 0);
      check("full_rd_addr", bus.ireq_addr, 64'h8000_0200);
      check("full_rd_count", 64'(bus.count), 64'd0);

      // Asynchronous reset while draining
      do_reset();
      cycle(0, '0, 0, 1, 0);
      cycle(0, '0, 1, 0, 0);
      cycle(1, 64'h8000_0400, 0, 0, 0);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.iresp_data_ok  = 1'b0;
      #1;
      check("drain_before_rst", 64'(bus.ireq_valid), 64'd1);
      #1 reset = 1'b0;
      #1;
      check("async_rst_ireq", 64'(bus.ireq_valid), 64'd0);
      check("async_rst_out", 64'(bus.out_valid), 64'd0);
      check("async_rst_count", 64'(bus.count), 64'd0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      cycle(0, '0, 0, 1, 0);
      cycle(0, '0, 1, 1, 0);
      cycle(0, '0, 0, 1, 0);

      // Random traffic, including redirects near the top of the address space
      for (int i = 0; i < 4000; i++) begin
         bit          rd;
         logic [63:0] rpc;
         rd  = ($urandom_range(0, 9) == 0);
         rpc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF4
                                           : {32'($urandom), 32'($urandom)};
         cycle(rd, rpc, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0), 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
